// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive-FIFO drain block.
// Contents: FSM state encoding, header bit positions, receive-FIFO base
// address, SFF/EFF header lengths and the frame-length helper.
package can_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned GAP_W        = 4;

    // Frame header (byte 0) layout
    localparam int unsigned HDR_FF_BIT   = 7;
    localparam int unsigned HDR_RTR_BIT  = 6;
    localparam int unsigned HDR_DLC_MSB  = 3;
    localparam int unsigned HDR_DLC_LSB  = 0;

    // Extended-mode mapping: byte i of the head frame lives at BASE_ADDR + i
    localparam int unsigned BASE_ADDR    = 16;
    localparam int unsigned SFF_HDR_LEN  = 3;
    localparam int unsigned EFF_HDR_LEN  = 5;
    localparam int unsigned MAX_DATA_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_REL  = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    // Total frame length in bytes (3..13): header bytes plus clamped DLC,
    // remote frames carry no data bytes.
    function automatic logic [IDX_W-1:0] frame_len(
        input logic             ff,
        input logic             rtr,
        input logic [IDX_W-1:0] dlc
    );
        logic [IDX_W-1:0] len;
        len = ff ? IDX_W'(EFF_HDR_LEN) : IDX_W'(SFF_HDR_LEN);
        if (!rtr) begin
            len = len + ((dlc > IDX_W'(MAX_DATA_LEN)) ? IDX_W'(MAX_DATA_LEN) : dlc);
        end
        return len;
    endfunction

endpackage

// File: rtl/can_rx_drain.sv
// Drains complete frames from the CAN receive FIFO and presents them as a
// byte stream with valid/ready handshake, then releases the frame.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reset_mode        controller reset mode, aborts the frame in progress
//   info_empty        FIFO holds no complete frame (sampled in IDLE only)
//   fifo_data         FIFO read data, valid one cycle after fifo_addr changes
//   fifo_overrun      overrun flag of the head frame
//   fifo_addr         FIFO byte address (16 + byte index)
//   release_buffer    one-cycle pulse freeing the head frame
//   m_data/m_valid/m_ready/m_last/m_overrun   outgoing byte stream
//   frame_cnt         count of released frames, wraps
module can_rx_drain
    import can_pkg::*;
#(
    parameter int unsigned U_DLY   = 1,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset_mode,
    input  logic              info_empty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_overrun,
    output logic [ADDR_W-1:0] fifo_addr,
    output logic              release_buffer,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              m_overrun,
    output logic [CNT_W-1:0]  frame_cnt
);

    // Elaboration-time parameter sanity; assignments here are zero-delay.
    if (GAP_CYC < 2 || GAP_CYC > 15) begin : g_gap_chk
        $error("can_rx_drain: GAP_CYC must be in 2..15");
    end
    if (U_DLY > 255) begin : g_dly_chk
        $error("can_rx_drain: U_DLY out of range");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               ovr_q, ovr_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic               rel_q, rel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   hdr_len;
    logic [IDX_W-1:0]   cur_len;

    // Length decoded straight from the header byte on the FIFO read port
    assign hdr_len = frame_len(fifo_data[HDR_FF_BIT], fifo_data[HDR_RTR_BIT],
                               fifo_data[HDR_DLC_MSB:HDR_DLC_LSB]);
    // At index 0 the latched length is not yet valid, use the live header
    assign cur_len = (idx_q == '0) ? hdr_len : len_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ovr_d   = ovr_q;
        len_d   = len_q;
        rel_d   = 1'b0;
        cnt_d   = cnt_q;
        gap_d   = gap_q;

        // A release pulse already on the wire is always counted
        if (state_q == ST_REL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (reset_mode) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            addr_d  = ADDR_W'(BASE_ADDR);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!info_empty) begin
                        state_d = ST_ADDR;
                        idx_d   = '0;
                        addr_d  = ADDR_W'(BASE_ADDR);
                    end
                end
                ST_ADDR: begin
                    state_d = ST_CAPT;
                end
                ST_CAPT: begin
                    data_d  = fifo_data;
                    valid_d = 1'b1;
                    last_d  = (idx_q == cur_len - IDX_W'(1));
                    if (idx_q == '0) begin
                        len_d = hdr_len;
                        ovr_d = fifo_overrun;
                    end
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (m_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            state_d = ST_REL;
                            rel_d   = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_ADDR;
                        end
                    end
                end
                ST_REL: begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(GAP_CYC - 1);
                    idx_d   = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
            len_q   <= '0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
            len_q   <= len_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign fifo_addr      = addr_q;
    assign release_buffer = rel_q;
    assign m_data         = data_q;
    assign m_valid        = valid_q;
    assign m_last         = last_q;
    assign m_overrun      = ovr_q;
    assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_can_rx_drain.sv
// Bench for can_rx_drain: a queue-based FIFO model feeds frames, and a
// negedge checker compares every presented byte against the head frame.
module tb_can_rx_drain;

    localparam int unsigned GAP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        reset_mode;
    logic        info_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_overrun = 1'b0;
    logic [5:0]  fifo_addr;
    logic        release_buffer;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        m_overrun;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    can_rx_drain #(.U_DLY(1), .GAP_CYC(GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .reset_mode     (reset_mode),
        .info_empty     (info_empty),
        .fifo_data      (fifo_data),
        .fifo_overrun   (fifo_overrun),
        .fifo_addr      (fifo_addr),
        .release_buffer (release_buffer),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .m_overrun      (m_overrun),
        .frame_cnt      (frame_cnt)
    );

    // Frames waiting in the receive FIFO; byte i is bits [8i+7:8i]
    logic [103:0] frm_q[$];
    bit           ovr_q[$];

    int checks = 0;
    int errors = 0;

    int          pos = 0;
    int          cyc = 0;
    int          exp_cnt = 0;
    int          pushed = 0;
    bit          hold = 1'b0;
    bit          exp_inv = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic        hold_last = 1'b0;
    logic        hold_ovr = 1'b0;
    int          peak = 16;
    int          last_len = 0;
    int          last_peak = 0;
    int          last_spacing = 0;
    int          prev_rel = -1;
    logic [7:0]  last_data = 8'h00;
    bit          last_ovr = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          rm_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame length straight from the header rules
    function automatic int model_len(input logic [7:0] hdr);
        int n;
        int dlc;
        n   = hdr[7] ? 5 : 3;
        dlc = int'(hdr[3:0]);
        if (!hdr[6]) n += (dlc > 8) ? 8 : dlc;
        return n;
    endfunction

    function automatic logic [103:0] rnd_frame();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[103:0];
    endfunction

    // Receive FIFO: registered read port, pop on release
    always @(posedge clk) begin
        logic [103:0] hf;
        int a;
        if (release_buffer && frm_q.size() > 0) begin
            void'(frm_q.pop_front());
            void'(ovr_q.pop_front());
        end
        info_empty   <= (frm_q.size() == 0);
        fifo_overrun <= (ovr_q.size() > 0) ? ovr_q[0] : 1'b0;
        a = int'(fifo_addr) - 16;
        if (frm_q.size() > 0 && a >= 0 && a < 13) begin
            hf = frm_q[0];
            fifo_data <= hf[a*8 +: 8];
        end else begin
            fifo_data <= 8'($urandom);
        end
    end

    // Per-cycle checker against the head-frame model
    always @(negedge clk) begin
        logic [103:0] hf;
        int L;
        if (rst) begin
            pos     = 0;
            hold    = 1'b0;
            exp_inv = 1'b0;
            peak    = 16;
        end else begin
            cyc++;
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            checks++;
            if (fifo_addr < 6'd16 || fifo_addr > 6'd28) begin
                errors++;
                $display("FAIL fifo_addr_range: got %0d expected 16..28", fifo_addr);
            end
            if (int'(fifo_addr) > peak) peak = int'(fifo_addr);
            if (exp_inv) begin
                chk("valid_after_abort", 32'(m_valid), 32'd0);
                chk("release_after_abort", 32'(release_buffer), 32'd0);
            end
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(hold_data));
                chk("hold_last", 32'(m_last), 32'(hold_last));
                chk("hold_ovr", 32'(m_overrun), 32'(hold_ovr));
            end
            if (release_buffer) begin
                if (frm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL release_without_frame: got pulse expected none");
                end else begin
                    hf = frm_q[0];
                    chk("bytes_per_frame", 32'(pos), 32'(model_len(hf[7:0])));
                    last_ovr = ovr_q[0];
                end
                if (prev_rel >= 0) begin
                    last_spacing = cyc - prev_rel;
                    checks++;
                    if (last_spacing < int'(GAP) + 1) begin
                        errors++;
                        $display("FAIL release_spacing: got %0d expected >= %0d", last_spacing, GAP + 1);
                    end
                end
                prev_rel  = cyc;
                last_len  = pos;
                last_peak = peak;
                exp_cnt++;
                pos  = 0;
                peak = 16;
            end
            exp_inv = 1'b0;
            hold    = 1'b0;
            if (reset_mode) begin
                pos     = 0;
                peak    = 16;
                exp_inv = 1'b1;
            end else if (m_valid && m_ready) begin
                if (frm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_without_frame: got %0h expected nothing", m_data);
                end else begin
                    hf = frm_q[0];
                    L  = model_len(hf[7:0]);
                    chk("byte_data", 32'(m_data), 32'(hf[pos*8 +: 8]));
                    chk("byte_last", 32'(m_last), (pos == L - 1) ? 32'd1 : 32'd0);
                    chk("byte_overrun", 32'(m_overrun), 32'(ovr_q[0]));
                    last_data = m_data;
                    pos++;
                end
            end else if (m_valid) begin
                hold      = 1'b1;
                hold_data = m_data;
                hold_last = m_last;
                hold_ovr  = m_overrun;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [103:0] f, input bit ovr);
        frm_q.push_back(f);
        ovr_q.push_back(ovr);
        pushed++;
    endtask

    task automatic settle();
        reset_mode = 1'b0;
        m_ready    = 1'b1;
        repeat (GAP + 4) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (frm_q.size() != 0 && n < budget) begin
            m_ready    = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            reset_mode = rm_rand ? ($urandom_range(0, 39) == 0) : 1'b0;
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d frames left expected 0", frm_q.size());
        end
        settle();
    endtask

    // Stall (7 cycles, ready low) or abort (reset_mode) when byte at_pos is shown
    task automatic special(input int at_pos, input bit do_abort);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (frm_q.size() != 0 && n < 1000) begin
            if (!done && pos == at_pos && m_valid) begin
                done    = 1'b1;
                m_ready = 1'b0;
                if (do_abort) begin
                    reset_mode = 1'b1;
                    tick();
                    reset_mode = 1'b0;
                end else begin
                    repeat (7) tick();
                end
                m_ready = 1'b1;
            end
            tick();
            n++;
        end
        checks++;
        if (n >= 1000 || !done) begin
            errors++;
            $display("FAIL special_seq: got done=%0d cycles=%0d expected done=1", done, n);
        end
        settle();
    endtask

    initial begin
        logic [103:0] f;
        rst        = 1'b1;
        reset_mode = 1'b0;
        m_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_addr", 32'(fifo_addr), 32'd16);
        chk("rst_release", 32'(release_buffer), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_overrun", 32'(m_overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;

        // SFF, DLC 2: 02 12 34 AA BB
        f = rnd_frame();
        f[7:0]   = 8'h02;
        f[15:8]  = 8'h12;
        f[23:16] = 8'h34;
        f[31:24] = 8'hAA;
        f[39:32] = 8'hBB;
        push(f, 1'b0);
        drain(400);
        chk("sff_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("sff_bytes", 32'(last_len), 32'd5);
        chk("sff_last_byte", 32'(last_data), 32'hBB);
        chk("sff_peak_addr", 32'(last_peak), 32'd20);

        // EFF remote frame, DLC 8
        f = rnd_frame();
        f[7:0] = 8'hC8;
        push(f, 1'b0);
        drain(400);
        chk("rtr_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("rtr_bytes", 32'(last_len), 32'd5);
        chk("rtr_peak_addr", 32'(last_peak), 32'd20);

        // SFF with DLC 15 clamps to 8 data bytes
        f = rnd_frame();
        f[7:0] = 8'h0F;
        push(f, 1'b0);
        drain(400);
        chk("dlc15_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("dlc15_bytes", 32'(last_len), 32'd11);
        chk("dlc15_peak_addr", 32'(last_peak), 32'd26);

        // Backpressure on byte 2
        f = rnd_frame();
        f[7:0] = 8'h08;
        push(f, 1'b0);
        special(2, 1'b0);
        chk("stall_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("stall_bytes", 32'(last_len), 32'd11);

        // Abort at byte 3, frame then re-read from the start
        f = rnd_frame();
        f[7:0] = 8'h03;
        push(f, 1'b0);
        special(3, 1'b1);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd5);
        chk("abort_bytes", 32'(last_len), 32'd6);

        // Back-to-back, second frame tagged overrun
        f = rnd_frame();
        f[7:0] = 8'h02;
        push(f, 1'b0);
        f = rnd_frame();
        f[7:0] = 8'h81;
        push(f, 1'b1);
        drain(600);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd7);
        chk("b2b_overrun", 32'(last_ovr), 32'd1);
        chk("b2b_spacing", 32'(last_spacing), 32'(GAP + 2 + 3 * 6));

        // Randomized headers, payloads, backpressure and aborts
        rdy_rand = 1'b1;
        rm_rand  = 1'b1;
        for (int b = 0; b < 10; b++) begin
            int k;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                push(rnd_frame(), 1'($urandom_range(0, 1)));
            end
            drain(4000);
        end
        rdy_rand = 1'b0;
        rm_rand  = 1'b0;
        settle();
        chk("all_released", 32'(exp_cnt), 32'(pushed));
        chk("final_frame_cnt", 32'(frame_cnt), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
